onchip_memory_dp_param: RTL and testbench
=========================================

// Module: onchip_memory_dp_param
// PURPOSE
//  Parametrised true-dual-port on-chip RAM with two Avalon-MM slaves (s1, s2) on one clock.
//  Adds selectable read latency, readdatavalid/waitrequest handshake,
//  deterministic same-address collision resolution, mixed-port write-to-read forwarding,
//  and an optional zero-fill sweep after reset.
//  Sits in the Qsys system as frame/line scratch buffer between the MIPI pipeline and the CPU.
// PARAMETERS
//  DATA_W          128  data width per port, multiple of 8
//  ADDR_W          15   word address width; depth = 2**ADDR_W
//  RD_LAT          1    read latency in cycles, 1 or 2; 2 adds output register
//  CLEAR_ON_RESET  1    1 = zero-fill all words after reset before accepting traffic
// PORTS
//  clk              in   1          system clock
//  reset            in   1          asynchronous, active-high reset
//  clken            in   1          global clock enable; low freezes all state
//  sN_address       in   ADDR_W     word address (N = 1, 2)
//  sN_chipselect    in   1          slave select
//  sN_read          in   1          read request
//  sN_write         in   1          write request
//  sN_byteenable    in   DATA_W/8   byte lane enables for writes
//  sN_writedata     in   DATA_W     write data
//  sN_readdata      out  DATA_W     read data, valid with sN_readdatavalid
//  sN_readdatavalid out  1          one-cycle pulse per accepted read
//  sN_waitrequest   out  1          high = request not accepted this cycle
//  init_done        out  1          high once the RAM is usable
// BEHAVIOUR
//  - Reset values: readdata 0, readdatavalid 0, waitrequest 1, init_done 0, FSM = CLEAR (CLEAR_ON_RESET=1) else READY.
//  - RAM contents are not reset; only control state is.
//  - FSM CLEAR: internal port A writes 0, all lanes, addr 0..2**ADDR_W-1, one word per enabled cycle.
//    Both waitrequests stay high. After the last address -> READY, init_done=1 next cycle.
//  - FSM READY: waitrequest = ~clken. Request accepted when chipselect & (read|write) & ~waitrequest.
//  - Read: readdatavalid and readdata appear exactly RD_LAT enabled cycles after acceptance.
//    Back-to-back reads run at one per cycle; no reordering.
//  - read & write together on one port is illegal; the write is performed, the read is dropped
//    (no readdatavalid); a sim assertion fires.
//  - Write: byte lanes with byteenable=1 are updated at the accepting edge; no response.
//  - Collision, both ports write the same address in one cycle:
//    * s1 lanes win on overlapping enables (s2 byteenable masked by ~s1 byteenable);
//    * non-overlapping lanes from both ports are committed.
//  - Mixed read-during-write: port reads an address the other port writes in the same cycle ->
//    returns NEW data (merged with old for disabled lanes) via bypass.
//    Same-port read-after-write next cycle returns new data.
//  - clken=0: RAM, pipeline, sweep counter and valid shift regs hold; no pulses emitted.
//  - reset asserted mid-CLEAR or mid-read: FSM returns to the reset state, in-flight readdatavalid
//    cleared, sweep restarts from address 0.
//  - Sweep counter is ADDR_W+1 bits; terminal detect on MSB, no wrap.
// STRUCTURE
//  - Package onchip_mem_pkg: FSM state enum {CLEAR, READY}, localparam BE_W = DATA_W/8,
//    function byte_merge(old, new, be).
//  - Sub-module ram_tdp_core: inferred true-dual-port byte-enabled RAM, no reset, one clock,
//    read-old-data per port.
//  - Top holds: FSM, sweep counter, collision masking, bypass compare (address + write-lane
//    registers), RD_LAT valid/data pipelines.
// TESTING
//  - Reset release, CLEAR_ON_RESET=1, ADDR_W=4: waitrequest high 16 cycles, init_done rises
//    at cycle 17; s1 read any addr -> 0.
//  - s1 write addr 5 = 0x..AA all lanes, s2 read addr 5 next cycle, RD_LAT=2 -> readdatavalid
//    2 cycles later, data 0x..AA.
//  - Both write addr 3 same cycle: s1 be=0x00FF data all-11, s2 be=0xFFFF data all-22 ->
//    readback lanes 0-7 = 0x11, lanes 8-15 = 0x22.
//  - s1 writes addr 7 be=0x0001 data 0x5A while s2 reads addr 7 (old 0) same cycle ->
//    s2 readdata = 0x...005A.
//  - clken low 3 cycles during burst of 4 reads -> 4 readdatavalid pulses, order kept,
//    none while clken low.
//  - reset pulsed mid-CLEAR at address 9 -> init_done stays 0, sweep restarts at 0,
//    full 16-cycle clear repeats.

Source files
------------

// File: rtl/onchip_memory_dp_param_pkg.sv
// Shared types and helpers for the dual-port scratch RAM.
// Byte merge is per byte so it stays width-agnostic for any DATA_W.
package onchip_mem_pkg;
   typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

   localparam int DATA_W_DEF = 128;
   localparam int BE_W       = DATA_W_DEF / 8;

   function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                             input logic [7:0] new_b,
                                             input logic       be);
      return be ? new_b : old_b;
   endfunction
endpackage

// File: rtl/onchip_memory_dp_param_if.sv
// Avalon-MM slave bundle for one RAM port; master side drives requests.
interface onchip_memory_dp_param_if #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 15
);
   logic [ADDR_W-1:0]   address;
   logic                chipselect;
   logic                read;
   logic                write;
   logic [DATA_W/8-1:0] byteenable;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;
   logic                waitrequest;

   modport master (output address, chipselect, read, write, byteenable, writedata,
                   input  readdata, readdatavalid, waitrequest);
   modport slave  (input  address, chipselect, read, write, byteenable, writedata,
                   output readdata, readdatavalid, waitrequest);
endinterface

// File: rtl/onchip_memory_dp_param_ram.sv
// Inferred true-dual-port byte-enabled RAM, single clock, read-old-data on both ports.
module ram_tdp_core #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 15
) (
   input  logic                i_clk,
   input  logic                i_en,
   input  logic                i_a_we,
   input  logic [DATA_W/8-1:0] i_a_be,
   input  logic [ADDR_W-1:0]   i_a_addr,
   input  logic [DATA_W-1:0]   i_a_wdata,
   output logic [DATA_W-1:0]   o_a_q,
   input  logic                i_b_we,
   input  logic [DATA_W/8-1:0] i_b_be,
   input  logic [ADDR_W-1:0]   i_b_addr,
   input  logic [DATA_W-1:0]   i_b_wdata,
   output logic [DATA_W-1:0]   o_b_q
);
   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge i_clk) begin
      if (i_en) begin
         o_a_q <= r_mem[i_a_addr];
         o_b_q <= r_mem[i_b_addr];
         for (int i = 0; i < DATA_W/8; i++) begin
            if (i_a_we && i_a_be[i]) r_mem[i_a_addr][i*8 +: 8] <= i_a_wdata[i*8 +: 8];
            if (i_b_we && i_b_be[i]) r_mem[i_b_addr][i*8 +: 8] <= i_b_wdata[i*8 +: 8];
         end
      end
   end
endmodule

// File: rtl/onchip_memory_dp_param.sv
// Dual Avalon-MM scratch RAM: post-reset zero sweep, collision masking (s1 wins),
// cross-port write bypass and RD_LAT-deep read pipelines.
module onchip_memory_dp_param
   import onchip_mem_pkg::*;
#(
   parameter int DATA_W         = DATA_W_DEF,
   parameter int ADDR_W         = 15,
   parameter int RD_LAT         = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clken,
   onchip_memory_dp_param_if.slave s1,
   onchip_memory_dp_param_if.slave s2,
   output logic init_done
);
   localparam int BEW = DATA_W / 8;

   state_e                     r_state, w_state_nx;
   logic [ADDR_W:0]            r_sweep, w_sweep_nx;
   logic                       r_init_done, w_clr, w_wait, w_collide;
   logic [1:0]                 w_cs, w_read, w_write, w_acc, w_wr, w_rd, w_rvalid;
   logic [1:0][ADDR_W-1:0]     w_addr;
   logic [1:0][BEW-1:0]        w_be_req, w_be;
   logic [1:0][DATA_W-1:0]     w_wdata, w_q, w_rdata;

   assign w_cs     = {s2.chipselect, s1.chipselect};
   assign w_read   = {s2.read,       s1.read};
   assign w_write  = {s2.write,      s1.write};
   assign w_addr   = {s2.address,    s1.address};
   assign w_be_req = {s2.byteenable, s1.byteenable};
   assign w_wdata  = {s2.writedata,  s1.writedata};

   assign w_wait = reset | (r_state != READY) | ~clken;
   assign w_acc  = w_cs & (w_read | w_write) & {2{~w_wait}};
   assign w_wr   = w_acc & w_write;
   // A read paired with a write on the same port is dropped; the write still lands.
   assign w_rd   = w_acc & w_read & ~w_write;

   assign w_collide = (&w_wr) && (w_addr[0] == w_addr[1]);
   assign w_be[0]   = w_be_req[0];
   assign w_be[1]   = w_collide ? (w_be_req[1] & ~w_be_req[0]) : w_be_req[1];

   always_comb begin
      w_state_nx = r_state;
      w_sweep_nx = r_sweep;
      w_clr      = 1'b0;
      case (r_state)
         CLEAR: begin
            w_clr      = ~reset;
            w_sweep_nx = r_sweep + 1'b1;
            if (w_sweep_nx[ADDR_W]) w_state_nx = READY;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
         r_sweep     <= '0;
         r_init_done <= 1'b0;
      end else if (clken) begin
         r_state     <= w_state_nx;
         r_sweep     <= w_sweep_nx;
         r_init_done <= (r_state == READY);
      end
   end

   assign init_done = r_init_done;

   ram_tdp_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .i_clk     (clk),
      .i_en      (clken),
      .i_a_we    (w_clr | w_wr[0]),
      .i_a_be    (w_clr ? {BEW{1'b1}} : w_be[0]),
      .i_a_addr  (w_clr ? r_sweep[ADDR_W-1:0] : w_addr[0]),
      .i_a_wdata (w_clr ? {DATA_W{1'b0}} : w_wdata[0]),
      .o_a_q     (w_q[0]),
      .i_b_we    (w_wr[1]),
      .i_b_be    (w_be[1]),
      .i_b_addr  (w_addr[1]),
      .i_b_wdata (w_wdata[1]),
      .o_b_q     (w_q[1])
   );

   for (genvar p = 0; p < 2; p++) begin : g_port
      localparam int O = 1 - p;
      logic              w_hit, r_hit;
      logic [BEW-1:0]    r_bbe;
      logic [DATA_W-1:0] r_bdata, w_mrg;
      logic [RD_LAT:1]   r_vld;

      // The RAM returns old data when the other port writes the same word this
      // cycle, so capture that write and overlay it one cycle later.
      assign w_hit = w_rd[p] & w_wr[O] & (w_addr[p] == w_addr[O]);

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_hit   <= 1'b0;
            r_bbe   <= '0;
            r_bdata <= '0;
            r_vld   <= '0;
         end else if (clken) begin
            r_hit   <= w_hit;
            r_bbe   <= w_be[O];
            r_bdata <= w_wdata[O];
            r_vld   <= RD_LAT'({r_vld, w_rd[p]});
         end
      end

      for (genvar b = 0; b < BEW; b++) begin : g_byte
         assign w_mrg[b*8 +: 8] = byte_merge(w_q[p][b*8 +: 8], r_bdata[b*8 +: 8], r_hit & r_bbe[b]);
      end

      if (RD_LAT == 1) begin : g_lat1
         assign w_rdata[p] = r_vld[1] ? w_mrg : '0;
      end else begin : g_lat2
         logic [DATA_W-1:0] r_out;
         always_ff @(posedge clk or posedge reset) begin
            if (reset)      r_out <= '0;
            else if (clken) r_out <= w_mrg;
         end
         assign w_rdata[p] = r_out;
      end

      assign w_rvalid[p] = r_vld[RD_LAT] & clken;
   end

   assign s1.readdata      = w_rdata[0];
   assign s2.readdata      = w_rdata[1];
   assign s1.readdatavalid = w_rvalid[0];
   assign s2.readdatavalid = w_rvalid[1];
   assign s1.waitrequest   = w_wait;
   assign s2.waitrequest   = w_wait;

   a_s1_rw: assert property (@(posedge clk) disable iff (reset) !(w_acc[0] && w_read[0] && w_write[0]));
   a_s2_rw: assert property (@(posedge clk) disable iff (reset) !(w_acc[1] && w_read[1] && w_write[1]));
endmodule

// File: tb/tb_onchip_memory_dp_param.sv
// Directed bench: ADDR_W=4, RD_LAT=2, zero sweep enabled; inputs driven 1ns after
// the rising edge, outputs sampled on the falling edge.
module tb_onchip_memory_dp_param;
   logic clk, reset, clken, init_done;
   int   total = 0;
   int   bad   = 0;

   onchip_memory_dp_param_if #(.DATA_W(128), .ADDR_W(4)) m1 ();
   onchip_memory_dp_param_if #(.DATA_W(128), .ADDR_W(4)) m2 ();

   onchip_memory_dp_param #(.DATA_W(128), .ADDR_W(4), .RD_LAT(2), .CLEAR_ON_RESET(1)) dut (
      .clk(clk), .reset(reset), .clken(clken), .s1(m1), .s2(m2), .init_done(init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish before 100us");
      $fatal(1);
   end

   typedef struct {
      bit           simul;
      int           wp;
      int           rp;
      logic [3:0]   a;
      logic [15:0]  be;
      logic [127:0] wd;
      logic [127:0] exp;
      string        nm;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit s, int wp, int rp, logic [3:0] a, logic [15:0] be,
                               logic [127:0] wd, logic [127:0] exp, string nm);
      vec_t v;
      v.simul = s; v.wp = wp; v.rp = rp; v.a = a; v.be = be; v.wd = wd; v.exp = exp; v.nm = nm;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int p, input logic cs, input logic rd, input logic wr,
                      input logic [3:0] a, input logic [15:0] be, input logic [127:0] d);
      if (p == 1) begin
         m1.chipselect = cs; m1.read = rd; m1.write = wr;
         m1.address = a; m1.byteenable = be; m1.writedata = d;
      end else begin
         m2.chipselect = cs; m2.read = rd; m2.write = wr;
         m2.address = a; m2.byteenable = be; m2.writedata = d;
      end
   endtask

   task automatic idle(input int p);
      drv(p, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 128'h0);
   endtask

   function automatic logic vld(input int p);
      return (p == 1) ? m1.readdatavalid : m2.readdatavalid;
   endfunction

   function automatic logic [127:0] rdat(input int p);
      return (p == 1) ? m1.readdata : m2.readdata;
   endfunction

   // Request already accepted at the last edge: no pulse one cycle on, pulse two cycles on.
   task automatic wait_rsp(input int p, input string nm, input logic [127:0] exp);
      @(negedge clk);
      chk({nm, "_early"}, 128'(vld(p)), 128'h0);
      tick();
      @(negedge clk);
      chk({nm, "_vld"}, 128'(vld(p)), 128'h1);
      chk(nm, rdat(p), exp);
   endtask

   task automatic rd_chk(input int p, input logic [3:0] a, input logic [127:0] exp, input string nm);
      drv(p, 1'b1, 1'b1, 1'b0, a, 16'h0, 128'h0);
      tick();
      idle(p);
      wait_rsp(p, nm, exp);
   endtask

   task automatic wr(input int p, input logic [3:0] a, input logic [15:0] be, input logic [127:0] d);
      drv(p, 1'b1, 1'b0, 1'b1, a, be, d);
      tick();
      idle(p);
   endtask

   // Release reset and check the 16-cycle sweep window and the init_done rise.
   task automatic release_and_sweep(input string nm);
      reset = 1'b0;
      repeat (15) tick();
      @(negedge clk);
      chk({nm, "_wait15"}, 128'(m1.waitrequest), 128'h1);
      tick();
      @(negedge clk);
      chk({nm, "_wait16"}, 128'({m2.waitrequest, init_done}), 128'h0);
      tick();
      @(negedge clk);
      chk({nm, "_init17"}, 128'(init_done), 128'h1);
      tick();
   endtask

   logic [127:0] got[$];
   int           low_pulses;
   logic [127:0] burst_exp [4];

   initial begin
      tbl.push_back(mk(0, 1, 2, 4'd5,  16'hFFFF, {16{8'hAA}}, {16{8'hAA}}, "wr5_rd5"));
      tbl.push_back(mk(0, 2, 1, 4'd6,  16'h00F0, {16{8'h33}}, 128'h0000000000000000_33333333_00000000, "lanes4to7"));
      tbl.push_back(mk(0, 1, 2, 4'd5,  16'hFF00, {16{8'h44}}, 128'h4444444444444444_AAAAAAAAAAAAAAAA, "upper_merge"));
      tbl.push_back(mk(0, 2, 1, 4'd15, 16'hFFFF, {16{8'hFF}}, {16{8'hFF}}, "top_addr"));
      tbl.push_back(mk(0, 1, 2, 4'd0,  16'h8001, 128'h0123456789ABCDEF_FEDCBA9876543210,
                       128'h0100000000000000_0000000000000010, "edge_lanes"));
      tbl.push_back(mk(0, 1, 1, 4'd9,  16'hFFFF, {16{8'h77}}, {16{8'h77}}, "same_port_raw"));
      tbl.push_back(mk(1, 1, 2, 4'd7,  16'h0001, {16{8'h5A}}, 128'h5A, "bypass_s1_to_s2"));
      tbl.push_back(mk(1, 2, 1, 4'd8,  16'h0300, {16{8'hC3}}, 128'h000000000000C3C3_0000000000000000, "bypass_s2_to_s1"));

      reset = 1'b1; clken = 1'b1;
      idle(1); idle(2);
      repeat (3) tick();
      @(negedge clk);
      chk("rst_wait", 128'({m1.waitrequest, m2.waitrequest}), 128'h3);
      chk("rst_vld_init", 128'({m1.readdatavalid, m2.readdatavalid, init_done}), 128'h0);
      chk("rst_rdata", m1.readdata | m2.readdata, 128'h0);
      tick();
      release_and_sweep("sweep");
      rd_chk(1, 4'd4, 128'h0, "post_clear_rd");

      foreach (tbl[i]) begin
         if (!tbl[i].simul) begin
            wr(tbl[i].wp, tbl[i].a, tbl[i].be, tbl[i].wd);
            rd_chk(tbl[i].rp, tbl[i].a, tbl[i].exp, tbl[i].nm);
         end else begin
            drv(tbl[i].wp, 1'b1, 1'b0, 1'b1, tbl[i].a, tbl[i].be, tbl[i].wd);
            drv(tbl[i].rp, 1'b1, 1'b1, 1'b0, tbl[i].a, 16'h0, 128'h0);
            tick();
            idle(1); idle(2);
            wait_rsp(tbl[i].rp, tbl[i].nm, tbl[i].exp);
         end
      end

      // Same-address write collision: s1 owns lanes 0-7, s2 keeps 8-15.
      drv(1, 1'b1, 1'b0, 1'b1, 4'd3, 16'h00FF, {16{8'h11}});
      drv(2, 1'b1, 1'b0, 1'b1, 4'd3, 16'hFFFF, {16{8'h22}});
      tick();
      idle(1); idle(2);
      rd_chk(1, 4'd3, 128'h2222222222222222_1111111111111111, "collision");

      // Four back-to-back reads with a three-cycle clken gap after the second.
      burst_exp[0] = 128'h4444444444444444_AAAAAAAAAAAAAAAA;
      burst_exp[1] = 128'h0000000000000000_33333333_00000000;
      burst_exp[2] = {16{8'hFF}};
      burst_exp[3] = 128'h2222222222222222_1111111111111111;
      low_pulses = 0;
      got.delete();
      fork
         begin
            drv(1, 1'b1, 1'b1, 1'b0, 4'd5, 16'h0, 128'h0);
            tick();
            drv(1, 1'b1, 1'b1, 1'b0, 4'd6, 16'h0, 128'h0);
            tick();
            clken = 1'b0;
            drv(1, 1'b1, 1'b1, 1'b0, 4'd15, 16'h0, 128'h0);
            repeat (3) tick();
            clken = 1'b1;
            tick();
            drv(1, 1'b1, 1'b1, 1'b0, 4'd3, 16'h0, 128'h0);
            tick();
            idle(1);
            repeat (4) tick();
         end
         begin
            for (int k = 0; k < 11; k++) begin
               @(negedge clk);
               if (m1.readdatavalid) begin
                  if (!clken) low_pulses++;
                  got.push_back(m1.readdata);
               end
            end
         end
      join
      chk("burst_count", 128'(got.size()), 128'd4);
      chk("burst_low_pulses", 128'(low_pulses), 128'h0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("burst_data%0d", k), (k < got.size()) ? got[k] : 128'hX, burst_exp[k]);
      end

      // Reset during an in-flight read, then again part-way through the sweep.
      wr(1, 4'd12, 16'hFFFF, {16{8'h99}});
      rd_chk(2, 4'd12, {16{8'h99}}, "pre_reset_rd");
      drv(1, 1'b1, 1'b1, 1'b0, 4'd12, 16'h0, 128'h0);
      tick();
      idle(1);
      reset = 1'b1;
      @(negedge clk);
      chk("midread_rst_vld", 128'(m1.readdatavalid), 128'h0);
      chk("midread_rst_rdata", m1.readdata, 128'h0);
      tick();
      @(negedge clk);
      chk("midread_rst_vld2", 128'(m1.readdatavalid), 128'h0);
      reset = 1'b0;
      repeat (9) tick();
      @(negedge clk);
      chk("midclear_state", 128'({init_done, m1.waitrequest}), 128'h1);
      tick();
      reset = 1'b1;
      tick();
      release_and_sweep("resweep");
      rd_chk(1, 4'd12, 128'h0, "resweep_addr12");
      rd_chk(2, 4'd9, 128'h0, "resweep_addr9");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
